ult_arbiter: RTL and testbench

- Owns both players' ultimate-ability meters.
- Arbitrates the single shared ultimate effect engine (projectile/effect datapath) between player 1 and player 2.
- Drives the 16-LED meter bar.
- Replaces the per-player divider and lockout logic; sits between the keyboard decoder, health source and effect engine.

---
 rtl/ult_pkg.sv | 18 +
 rtl/ult_arbiter_if.sv | 23 ++
 rtl/ult_meter.sv | 86 ++++++++
 rtl/ult_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ult_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ult_pkg.sv
// Shared types and constants for the ultimate-ability arbiter slice.
package ult_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACTIVE
    } ult_state_t;

    // Player identifiers as carried on eff_player
    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    // Default meter width (also LEDs per player)
    localparam int unsigned METER_BITS_DEF = 8;

endpackage

// File: rtl/ult_arbiter_if.sv
// Handshake bundle between the ult arbiter and the shared effect engine.
interface ult_arbiter_if;

    logic eff_valid;   // ult request offered to effect engine
    logic eff_player;  // owner of offer/active ult, 0 = P1, 1 = P2
    logic eff_ready;   // engine accepts offer
    logic eff_done;    // engine finished, one-cycle pulse

    modport master (
        output eff_valid,
        output eff_player,
        input  eff_ready,
        input  eff_done
    );

    modport slave (
        input  eff_valid,
        input  eff_player,
        output eff_ready,
        output eff_done
    );

endinterface

// File: rtl/ult_meter.sv
// Per-player ultimate meter: health-scaled recharge period, shift-fill meter,
// post-grant key lockout, pending request flag and registered ult_ready.
module ult_meter
    import ult_pkg::*;
#(
    parameter int unsigned TICK_SHIFT     = 22,
    parameter int unsigned METER_BITS     = METER_BITS_DEF,
    parameter int unsigned LOCKOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [3:0]            health,
    input  logic                  ult_key,
    input  logic                  grant,
    output logic [METER_BITS-1:0] meter,
    output logic                  ult_ready,
    output logic                  pending
);

    localparam logic [31:0] LOCK_LOAD = 32'(LOCKOUT_CYCLES);

    logic [31:0] period_cnt;
    logic [31:0] period_max;
    logic [31:0] lockout_cnt;
    logic        alive;
    logic        tick;

    assign alive      = (health != 4'd0);
    // Threshold follows health immediately; the running count is kept
    assign period_max = (32'(health) << TICK_SHIFT) - 32'd1;
    assign tick       = alive && (period_cnt >= period_max);

    // Recharge period counter, held at zero while dead
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
        end else if (!alive || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    // Meter fills one LED per tick from the bottom; shifting ones saturates naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meter <= '0;
        end else if (!alive || grant) begin
            meter <= '0;
        end else if (tick) begin
            meter <= {meter[METER_BITS-2:0], 1'b1};
        end
    end

    // Ready is registered from the meter, so it lags the meter by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ult_ready <= 1'b0;
        end else begin
            ult_ready <= (&meter) && alive;
        end
    end

    // Lockout also masks the stale ult_ready seen in the cycle after a grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lockout_cnt <= '0;
        end else if (grant) begin
            lockout_cnt <= LOCK_LOAD;
        end else if (lockout_cnt != '0) begin
            lockout_cnt <= lockout_cnt - 32'd1;
        end
    end

    // Pending request: death and grant clear it ahead of a new press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else if (!alive || grant) begin
            pending <= 1'b0;
        end else if (ult_key && ult_ready && (lockout_cnt == '0)) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/ult_arbiter.sv
// Ultimate arbiter top: two player meters, arbitration of the shared effect
// engine (IDLE/OFFER/ACTIVE), forced release on timeout and the LED bar.
// Optional macro ULT_BLINK_EN: full meters blink every BLINK_HALF cycles;
// without it a full meter shows steady all-ones.
module ult_arbiter
    import ult_pkg::*;
#(
    parameter int unsigned TICK_SHIFT     = 22,
    parameter int unsigned METER_BITS     = METER_BITS_DEF,
    parameter int unsigned LOCKOUT_CYCLES = 200000,
    parameter int unsigned ULT_TIMEOUT    = 50000000,
    parameter int unsigned BLINK_HALF     = 10000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [3:0]              p1_health,
    input  logic [3:0]              p2_health,
    input  logic                    p1_ult_key,
    input  logic                    p2_ult_key,
    ult_arbiter_if.master           eff,
    output logic                    p1_ult_ready,
    output logic                    p2_ult_ready,
    output logic                    ult_timeout,
    output logic [2*METER_BITS-1:0] led
);

    localparam logic [31:0] TMO_LAST = 32'(ULT_TIMEOUT - 1);

    ult_state_t            state, state_nxt;
    logic                  owner, owner_nxt;
    logic                  last_winner;
    logic [31:0]           tmo_cnt;
    logic [METER_BITS-1:0] p1_meter, p2_meter;
    logic                  p1_pend, p2_pend;
    logic                  p1_grant, p2_grant;
    logic                  owner_alive;
    logic                  timeout_hit;
    logic                  grant_fire;
    logic [METER_BITS-1:0] full_pat;

    ult_meter #(
        .TICK_SHIFT    (TICK_SHIFT),
        .METER_BITS    (METER_BITS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_p1_meter (
        .clk      (clk),
        .resetn   (resetn),
        .health   (p1_health),
        .ult_key  (p1_ult_key),
        .grant    (p1_grant),
        .meter    (p1_meter),
        .ult_ready(p1_ult_ready),
        .pending  (p1_pend)
    );

    ult_meter #(
        .TICK_SHIFT    (TICK_SHIFT),
        .METER_BITS    (METER_BITS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_p2_meter (
        .clk      (clk),
        .resetn   (resetn),
        .health   (p2_health),
        .ult_key  (p2_ult_key),
        .grant    (p2_grant),
        .meter    (p2_meter),
        .ult_ready(p2_ult_ready),
        .pending  (p2_pend)
    );

    assign owner_alive = (owner == PLAYER1) ? (p1_health != 4'd0) : (p2_health != 4'd0);
    assign timeout_hit = (tmo_cnt == TMO_LAST);
    assign grant_fire  = (state == OFFER) && eff.eff_ready && owner_alive;

    // State and owner register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= PLAYER1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state: owner is latched only on IDLE->OFFER
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (p1_pend || p2_pend) begin
                    state_nxt = OFFER;
                    if (p1_pend && p2_pend) begin
                        owner_nxt = ~last_winner;
                    end else begin
                        owner_nxt = p2_pend ? PLAYER2 : PLAYER1;
                    end
                end
            end
            OFFER: begin
                if (!owner_alive) begin
                    state_nxt = IDLE;
                end else if (eff.eff_ready) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (eff.eff_done || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: offer strobe, owner, and per-player grant
    always_comb begin
        eff.eff_valid  = (state == OFFER);
        eff.eff_player = owner;
        p1_grant       = grant_fire && (owner == PLAYER1);
        p2_grant       = grant_fire && (owner == PLAYER2);
    end

    // Tie-break history, ACTIVE timeout counter and forced-release pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_winner <= PLAYER2;
            tmo_cnt     <= '0;
            ult_timeout <= 1'b0;
        end else begin
            if (grant_fire) begin
                last_winner <= owner;
            end
            tmo_cnt     <= ((state == ACTIVE) && (state_nxt == ACTIVE)) ? tmo_cnt + 32'd1 : '0;
            ult_timeout <= (state == ACTIVE) && timeout_hit && !eff.eff_done;
        end
    end

`ifdef ULT_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_on;

    // Free-running blink phase; starts in the off half
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (blink_cnt == 32'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign full_pat = {METER_BITS{blink_on}};
`else
    logic unused_blink_half;
    assign unused_blink_half = ^32'(BLINK_HALF);
    assign full_pat          = '1;
`endif

    function automatic logic [METER_BITS-1:0] led_seg(
        input logic [3:0]            health,
        input logic [METER_BITS-1:0] meter,
        input logic [METER_BITS-1:0] full
    );
        if (health == 4'd0) begin
            return '0;
        end
        if (&meter) begin
            return full;
        end
        return meter;
    endfunction

    // LED bar: P1 on the upper half, P2 on the lower half
    always_comb begin
        led = {led_seg(p1_health, p1_meter, full_pat), led_seg(p2_health, p2_meter, full_pat)};
    end

endmodule

// File: tb/tb_ult_arbiter.sv
// Scoreboarded bench for ult_arbiter with reduced timing parameters.
module tb_ult_arbiter;

    localparam int TS  = 2;
    localparam int LK  = 8;
    localparam int TMO = 20;
    localparam int BH  = 4;
    localparam int S_IDLE = 0, S_OFFER = 1, S_ACTIVE = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  hl [2];
    logic        kl [2];
    logic        p1_ult_ready, p2_ult_ready, ult_timeout;
    logic [15:0] led;

    ult_arbiter_if eff_if ();

    ult_arbiter #(
        .TICK_SHIFT    (TS),
        .METER_BITS    (8),
        .LOCKOUT_CYCLES(LK),
        .ULT_TIMEOUT   (TMO),
        .BLINK_HALF    (BH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .p1_health   (hl[0]),
        .p2_health   (hl[1]),
        .p1_ult_key  (kl[0]),
        .p2_ult_key  (kl[1]),
        .eff         (eff_if),
        .p1_ult_ready(p1_ult_ready),
        .p2_ult_ready(p2_ult_ready),
        .ult_timeout (ult_timeout),
        .led         (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        p;
        logic        r1;
        logic        r2;
        logic        to;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_mon;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: meter kept as a count of lit LEDs
    int m_lvl [2], m_cnt [2], m_lock [2];
    bit m_pend [2], m_rdy [2];
    int m_st, m_tc;
    bit m_own, m_last, m_to;
    int m_bc;
    bit m_blk;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_cnt[i] = 0; m_lock[i] = 0; m_pend[i] = 0; m_rdy[i] = 0;
        end
        m_st = S_IDLE; m_tc = 0; m_own = 0; m_last = 1; m_to = 0;
        m_bc = 0; m_blk = 0;
    endtask

    function automatic logic [7:0] seg_exp(input int i);
        logic [7:0] full;
`ifdef ULT_BLINK_EN
        full = m_blk ? 8'hFF : 8'h00;
`else
        full = 8'hFF;
`endif
        if (hl[i] == 4'd0) return 8'h00;
        if (m_lvl[i] == 8) return full;
        return 8'((1 << m_lvl[i]) - 1);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.v   = (m_st == S_OFFER);
        e.p   = m_own;
        e.r1  = m_rdy[0];
        e.r2  = m_rdy[1];
        e.to  = m_to;
        e.led = {seg_exp(0), seg_exp(1)};
        return e;
    endfunction

    task automatic model_advance();
        int nl [2], nc [2], nk [2];
        bit np [2], nr [2], g [2], alive [2];
        int n_st, n_tc;
        bit n_own, n_last, n_to;
        for (int i = 0; i < 2; i++) begin
            alive[i] = (hl[i] != 4'd0);
            g[i] = (m_st == S_OFFER) && (int'(m_own) == i) && eff_if.eff_ready && alive[i];
        end
        for (int i = 0; i < 2; i++) begin
            int  period;
            bit  tick;
            period = int'(hl[i]) * (1 << TS);
            tick   = alive[i] && (m_cnt[i] >= period - 1);
            nc[i]  = (!alive[i] || tick) ? 0 : m_cnt[i] + 1;
            if (!alive[i] || g[i]) nl[i] = 0;
            else if (tick)         nl[i] = (m_lvl[i] < 8) ? m_lvl[i] + 1 : 8;
            else                   nl[i] = m_lvl[i];
            nr[i] = (m_lvl[i] == 8) && alive[i];
            nk[i] = g[i] ? LK : ((m_lock[i] > 0) ? m_lock[i] - 1 : 0);
            if (!alive[i] || g[i])                       np[i] = 0;
            else if (kl[i] && m_rdy[i] && m_lock[i] == 0) np[i] = 1;
            else                                         np[i] = m_pend[i];
        end
        n_st = m_st; n_own = m_own; n_last = m_last; n_tc = 0; n_to = 0;
        case (m_st)
            S_IDLE: if (m_pend[0] || m_pend[1]) begin
                n_st  = S_OFFER;
                n_own = (m_pend[0] && m_pend[1]) ? !m_last : !m_pend[0];
            end
            S_OFFER: begin
                if (!alive[m_own]) n_st = S_IDLE;
                else if (eff_if.eff_ready) begin
                    n_st = S_ACTIVE; n_last = m_own;
                end
            end
            default: begin
                if (eff_if.eff_done) n_st = S_IDLE;
                else if (m_tc == TMO - 1) begin
                    n_st = S_IDLE; n_to = 1;
                end else n_tc = m_tc + 1;
            end
        endcase
        if (m_bc == BH - 1) begin m_bc = 0; m_blk = !m_blk; end
        else m_bc = m_bc + 1;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = nl[i]; m_cnt[i] = nc[i]; m_lock[i] = nk[i];
            m_pend[i] = np[i]; m_rdy[i] = nr[i];
        end
        m_st = n_st; m_own = n_own; m_last = n_last; m_tc = n_tc; m_to = n_to;
    endtask

    // One cycle: queue the expected outputs for this cycle, advance model, move to next cycle
    task automatic step();
        if (!resetn) model_reset();
        exp_q.push_back(model_out());
        if (resetn) model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int st, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (m_st == st) break;
            step();
        end
    endtask

    task automatic wait_rdy(input int i, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (m_rdy[i]) break;
            step();
        end
    endtask

    // Monitor: compare DUT outputs at mid-cycle against queued expectations
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_mon = exp_q.pop_front();
            chk("eff_valid",    int'(eff_if.eff_valid),  int'(exp_mon.v));
            chk("eff_player",   int'(eff_if.eff_player), int'(exp_mon.p));
            chk("p1_ult_ready", int'(p1_ult_ready),      int'(exp_mon.r1));
            chk("p2_ult_ready", int'(p2_ult_ready),      int'(exp_mon.r2));
            chk("ult_timeout",  int'(ult_timeout),       int'(exp_mon.to));
            chk("led",          int'(led),               int'(exp_mon.led));
        end
    end

    initial begin
        resetn = 1'b0;
        hl[0] = 4'd3; hl[1] = 4'd3; kl[0] = 1'b0; kl[1] = 1'b0;
        eff_if.eff_ready = 1'b0; eff_if.eff_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step();
        resetn = 1'b1;

        // Recharge at health 3: one step every 12 cycles until full
        repeat (8 * 12 + 4) step();

        // Tie, stalled offer, then grant; P2 follows without re-press
        kl[0] = 1'b1; kl[1] = 1'b1;
        wait_st(S_OFFER, 10);
        repeat (5) step();
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0; step();
        kl[0] = 1'b0; kl[1] = 1'b0;
        repeat (3) step();
        eff_if.eff_done = 1'b1; step();
        eff_if.eff_done = 1'b0;
        wait_st(S_OFFER, 10);
        step();
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0;
        repeat (2) step();
        eff_if.eff_done = 1'b1; step();
        eff_if.eff_done = 1'b0; step();

        // Death while offering: offer dropped, no grant even with ready high
        hl[0] = 4'd1; hl[1] = 4'd1;
        wait_rdy(1, 300);
        kl[1] = 1'b1;
        wait_st(S_OFFER, 10);
        kl[1] = 1'b0;
        eff_if.eff_ready = 1'b1; hl[1] = 4'd0; step();
        eff_if.eff_ready = 1'b0;
        repeat (3) step();
        hl[1] = 4'd3;

        // Forced release: key held through grant exercises the lockout
        wait_rdy(0, 300);
        kl[0] = 1'b1;
        wait_st(S_OFFER, 10);
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0;
        repeat (25) step();
        kl[0] = 1'b0;

        // Done coincident with the last timeout cycle: no pulse
        wait_rdy(0, 300);
        kl[0] = 1'b1;
        wait_st(S_OFFER, 10);
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0; kl[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (m_st == S_ACTIVE && m_tc == TMO - 1) break;
            step();
        end
        eff_if.eff_done = 1'b1; step();
        eff_if.eff_done = 1'b0;
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(99) < 3) hl[i] = 4'($urandom_range(3));
                kl[i] = ($urandom_range(99) < 30);
            end
            eff_if.eff_ready = ($urandom_range(99) < 50);
            eff_if.eff_done  = ($urandom_range(99) < 15);
            step();
        end
        kl[0] = 1'b0; kl[1] = 1'b0;
        eff_if.eff_ready = 1'b0; eff_if.eff_done = 1'b0;
        hl[0] = 4'd1; hl[1] = 4'd1;
        repeat (4) step();

        // Async reset in ACTIVE, then P1 must win the first tie
        wait_st(S_IDLE, 40);
        wait_rdy(0, 300);
        kl[0] = 1'b1;
        wait_st(S_OFFER, 10);
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0; kl[0] = 1'b0;
        repeat (2) step();
        resetn = 1'b0;
        #1;
        chk("rst_eff_valid",  int'(eff_if.eff_valid),  0);
        chk("rst_eff_player", int'(eff_if.eff_player), 0);
        chk("rst_p1_ready",   int'(p1_ult_ready),      0);
        chk("rst_p2_ready",   int'(p2_ult_ready),      0);
        chk("rst_timeout",    int'(ult_timeout),       0);
        chk("rst_led",        int'(led),               0);
        step();
        resetn = 1'b1;
        kl[0] = 1'b1; kl[1] = 1'b1;
        wait_st(S_OFFER, 200);
        chk("first_tie_owner", int'(eff_if.eff_player), 0);
        eff_if.eff_ready = 1'b1; step();
        eff_if.eff_ready = 1'b0; kl[0] = 1'b0; kl[1] = 1'b0;
        eff_if.eff_done = 1'b1; step();
        eff_if.eff_done = 1'b0;
        wait_st(S_OFFER, 10);
        chk("second_tie_owner", int'(eff_if.eff_player), 1);
        repeat (4) step();

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
